adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
// - Capture scheduler in front of adc_frame_to_fifo: decides which ADC frames enter the event FIFO.
// - Gates each frame_valid from the ADC frame assembler on run state, decimation, FIFO free space and sequencer idle.
// - Supports continuous and N-frame burst capture. Keeps saturating accept/drop counters for the register block.
// PARAMETERS
// - WORDS_OUT   9    words pushed per frame by adc_frame_to_fifo; required free FIFO slots per frame
// - FIFO_DEPTH  64   event FIFO depth in words
// - LEVEL_W     7    width of fifo_level; must hold FIFO_DEPTH
// - CNT_W       16   width of drop counters and burst length
// PORTS
// - clk               in   1        system clock
// - rst_n             in   1        async assert, active-low reset
// - cfg_mode          in   1        0=continuous, 1=burst; latched on accepted start
// - cfg_decim         in   8        keep 1 of every (cfg_decim+1) frames; latched on start
// - cfg_burst_len     in   CNT_W    frames to accept in burst mode; latched on start
// - cmd_start         in   1        1-cycle pulse: begin capture
// - cmd_stop          in   1        1-cycle pulse: end capture
// - cmd_clr_cnt       in   1        1-cycle pulse: clear all counters
// - adc_frame_valid   in   1        1-cycle pulse, frame data valid on the same cycle
// - fifo_level        in   LEVEL_W  current event FIFO occupancy in words
// - seq_busy          in   1        adc_frame_to_fifo busy
// - seq_frame_valid   out  1        frame_valid to adc_frame_to_fifo; combinational gate of adc_frame_valid
// - running           out  1        state != IDLE
// - done_pulse        out  1        1-cycle pulse on DRAIN->IDLE
// - frames_accepted   out  32       saturating count of frames forwarded
// - drop_full         out  CNT_W    saturating count of selected frames dropped: insufficient FIFO space
// - drop_busy         out  CNT_W    saturating count of selected frames dropped: sequencer busy or in flight
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0. Counters 0. Latched cfg 0. Decimation phase 0. in_flight 0.
// - States:
//   - IDLE: a start moves to RUN and latches cfg. It also clears phase and frames_left=cfg_burst_len.
//     - In burst mode with cfg_burst_len==0, start goes straight to DRAIN.
//   - RUN: cmd_stop -> DRAIN. In burst mode, the accept that makes frames_left==0 -> DRAIN on the next edge.
//   - DRAIN: no forwarding. Leave when in_flight==0 and seq_busy==0 -> IDLE and assert done_pulse for that cycle.
// - cmd_start outside IDLE is ignored. cmd_stop in IDLE/DRAIN is ignored. cmd_start and cmd_stop on the same cycle: stop wins, and in IDLE nothing happens.
// - Decimation: every adc_frame_valid seen in RUN advances phase (mod decim+1). A frame is selected only when phase==0.
//   - A non-selected frame is never counted as a drop.
// - Forward condition for a selected frame: seq_busy==0, in_flight==0 and (FIFO_DEPTH - fifo_level) >= WORDS_OUT.
//   - When met, seq_frame_valid = adc_frame_valid in the same cycle (0 latency). This increments frames_accepted and decrements frames_left.
// - Drop priority when the condition fails: busy/in_flight is counted first (drop_busy). Otherwise drop_full.
// - in_flight set on forward; cleared on the first cycle after seq_busy has been seen high and then low.
//   - This covers the 1-cycle gap before busy rises and before fifo_level reflects the final push.
// - Free space uses LEVEL_W+1 bit unsigned arithmetic. fifo_level > FIFO_DEPTH is treated as full.
// - Counters saturate at all-ones and never wrap.
// - cmd_clr_cnt zeroes all counters. On the same cycle as an increment, clear wins.
// - Config inputs are not used outside the start cycle. Changing them mid-run has no effect.
// - Async reset mid-run: immediate IDLE, seq_frame_valid low. A partially pushed frame in adc_frame_to_fifo is that block's concern.
// STRUCTURE
// - Shared include adc_capture_defs.vh holds:
//   - state encodings ST_IDLE/ST_RUN/ST_DRAIN
//   - MODE_CONT/MODE_BURST
//   - default WORDS_OUT and FIFO_DEPTH shared with adc_frame_to_fifo
// - One sub-module, sat_counter (params W; ports inc, clr, q), instantiated for frames_accepted, drop_full and drop_busy.
// - State machine, decimation phase, frames_left and in_flight logic stay in adc_capture_ctrl.
// TESTING
// - Continuous mode, decim=0, level=0: 3 frames spaced 20 cycles -> 3 seq_frame_valid on the same cycle as the input, frames_accepted=3, no drops.
// - Decimation: decim=2, 9 frames spaced 20 cycles -> forward only frames 0, 3 and 6; accepted=3; drop_full=drop_busy=0.
// - Space: FIFO_DEPTH=64, level=56 -> frame dropped, drop_full=1. With level=55 -> forwarded.
// - Busy: frame during seq_busy=1, and a frame the cycle after a forward before busy rises -> both dropped, drop_busy=2, accepted unchanged.
// - Burst: len=2, 4 frames -> 2 forwarded, state DRAIN. After seq_busy falls, done_pulse exactly 1 cycle and running=0. len=0 -> done with 0 forwards.
// - Boundaries:
//   - start+stop same cycle -> stays IDLE.
//   - clr+increment same cycle -> counter 0.
//   - counter preset to near max -> holds 0xFFFF.
//   - rst_n low mid-RUN -> running=0 and outputs 0 asynchronously.

Source files
------------

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture scheduler: state and mode encodings plus
// default sizing shared with adc_frame_to_fifo.
package adc_capture_ctrl_pkg;

    localparam int unsigned WORDS_OUT_DEF  = 9;
    localparam int unsigned FIFO_DEPTH_DEF = 64;
    localparam int unsigned LEVEL_W_DEF    = 7;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned DECIM_W        = 8;
    localparam int unsigned ACC_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/adc_capture_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture scheduler: gates ADC frames into the event FIFO by run state, decimation,
// FIFO free space and sequencer availability; keeps saturating accept/drop counters.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int unsigned WORDS_OUT  = WORDS_OUT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned LEVEL_W    = LEVEL_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_mode,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic [CNT_W-1:0]   cfg_burst_len,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               cmd_clr_cnt,
    input  logic               adc_frame_valid,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               seq_busy,
    output logic               seq_frame_valid,
    output logic               running,
    output logic               done_pulse,
    output logic [ACC_W-1:0]   frames_accepted,
    output logic [CNT_W-1:0]   drop_full,
    output logic [CNT_W-1:0]   drop_busy
);

    localparam int unsigned FREE_W = LEVEL_W + 1;

    state_t               r_state;
    logic                 r_mode;
    logic [DECIM_W-1:0]   r_decim;
    logic [DECIM_W-1:0]   r_phase;
    logic [CNT_W-1:0]     r_frames_left;
    logic                 r_in_flight;
    logic                 r_busy_seen;
    logic                 r_done;

    logic [FREE_W-1:0]    w_level_ext;
    logic [FREE_W-1:0]    w_free;
    logic                 w_space_ok;
    logic                 w_blocked;
    logic                 w_sel;
    logic                 w_fwd;
    logic                 w_drop_busy;
    logic                 w_drop_full;
    logic                 w_last;
    logic [DECIM_W-1:0]   w_phase_next;

    // Occupancy beyond the FIFO depth is treated as no free space at all.
    assign w_level_ext  = FREE_W'(fifo_level);
    assign w_free       = FREE_W'(FIFO_DEPTH) - w_level_ext;
    assign w_space_ok   = (w_level_ext <= FREE_W'(FIFO_DEPTH)) && (w_free >= FREE_W'(WORDS_OUT));
    assign w_blocked    = seq_busy || r_in_flight;
    assign w_sel        = (r_state == ST_RUN) && adc_frame_valid && (r_phase == '0);
    assign w_fwd        = w_sel && !w_blocked && w_space_ok;
    assign w_drop_busy  = w_sel && w_blocked;
    assign w_drop_full  = w_sel && !w_blocked && !w_space_ok;
    assign w_last       = (r_mode == MODE_BURST) && (r_frames_left == CNT_W'(1));
    assign w_phase_next = (r_phase == r_decim) ? '0 : r_phase + DECIM_W'(1);

    assign seq_frame_valid = w_fwd;
    assign running         = (r_state != ST_IDLE);
    assign done_pulse      = r_done;

    // Run-state machine with configuration latched only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_CONT;
            r_decim       <= '0;
            r_phase       <= '0;
            r_frames_left <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start && !cmd_stop) begin
                        r_mode        <= cfg_mode;
                        r_decim       <= cfg_decim;
                        r_phase       <= '0;
                        r_frames_left <= cfg_burst_len;
                        r_state       <= ((cfg_mode == MODE_BURST) && (cfg_burst_len == '0))
                                         ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (adc_frame_valid) begin
                        r_phase <= w_phase_next;
                    end
                    if (w_fwd && (r_mode == MODE_BURST)) begin
                        r_frames_left <= r_frames_left - CNT_W'(1);
                    end
                    if (cmd_stop || (w_fwd && w_last)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_in_flight && !seq_busy) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A forwarded frame stays in flight until the sequencer has gone busy and back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= 1'b0;
            r_busy_seen <= 1'b0;
        end else if (w_fwd) begin
            r_in_flight <= 1'b1;
            r_busy_seen <= 1'b0;
        end else if (r_in_flight) begin
            if (seq_busy) begin
                r_busy_seen <= 1'b1;
            end else if (r_busy_seen) begin
                r_in_flight <= 1'b0;
                r_busy_seen <= 1'b0;
            end
        end
    end

    sat_counter #(.W(ACC_W)) u_cnt_accepted (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_fwd),
        .clr   (cmd_clr_cnt),
        .q     (frames_accepted)
    );

    sat_counter #(.W(CNT_W)) u_cnt_drop_full (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_drop_full),
        .clr   (cmd_clr_cnt),
        .q     (drop_full)
    );

    sat_counter #(.W(CNT_W)) u_cnt_drop_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_drop_busy),
        .clr   (cmd_clr_cnt),
        .q     (drop_busy)
    );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a frame-index based reference model.
module tb_adc_capture_ctrl;
    import adc_capture_ctrl_pkg::*;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned LEVEL_W    = 7;
    localparam int unsigned FIFO_DEPTH = 64;
    localparam int unsigned WORDS_OUT  = 9;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_mode;
    logic [DECIM_W-1:0] cfg_decim;
    logic [CNT_W-1:0]   cfg_burst_len;
    logic               cmd_start, cmd_stop, cmd_clr_cnt;
    logic               adc_frame_valid;
    logic [LEVEL_W-1:0] fifo_level;
    logic               seq_busy;
    logic               seq_frame_valid, running, done_pulse;
    logic [ACC_W-1:0]   frames_accepted;
    logic [CNT_W-1:0]   drop_full, drop_busy;
    logic               sc_inc, sc_clr;
    logic [3:0]         sc_q;

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .WORDS_OUT  (WORDS_OUT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEVEL_W    (LEVEL_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_mode        (cfg_mode),
        .cfg_decim       (cfg_decim),
        .cfg_burst_len   (cfg_burst_len),
        .cmd_start       (cmd_start),
        .cmd_stop        (cmd_stop),
        .cmd_clr_cnt     (cmd_clr_cnt),
        .adc_frame_valid (adc_frame_valid),
        .fifo_level      (fifo_level),
        .seq_busy        (seq_busy),
        .seq_frame_valid (seq_frame_valid),
        .running         (running),
        .done_pulse      (done_pulse),
        .frames_accepted (frames_accepted),
        .drop_full       (drop_full),
        .drop_busy       (drop_busy)
    );

    sat_counter #(.W(4)) u_sat4 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sc_inc),
        .clr   (sc_clr),
        .q     (sc_q)
    );

    int unsigned n_tests = 0, n_fail = 0;
    int unsigned cyc_no = 0, n_done_seen = 0;
    int unsigned busy_from = 0, busy_to = 0, g_gap = 1, g_blen = 3;
    int unsigned c_mode = 0, c_decim = 0, c_len = 0;

    // Reference model: capture phase flags, frame index since start, frames still wanted.
    bit              m_run, m_drain, m_burst, m_pend, m_saw, m_done;
    int unsigned     m_decim, m_frame_no, m_left;
    longint unsigned m_acc, m_dfull, m_dbusy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_drain = 0; m_burst = 0; m_pend = 0; m_saw = 0; m_done = 0;
        m_decim = 0; m_frame_no = 0; m_left = 0;
        m_acc = 0; m_dfull = 0; m_dbusy = 0;
        busy_from = 0; busy_to = 0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the gate, advance model.
    task automatic cyc(input bit st, input bit sp, input bit cl, input bit fv,
                       input int unsigned lvl, input bit xb);
        bit busy, sel, room, fwd, blocked, was_pend;
        @(negedge clk);
        chk("running", 64'(running), 64'(m_run || m_drain));
        chk("done_pulse", 64'(done_pulse), 64'(m_done));
        chk("frames_accepted", 64'(frames_accepted), m_acc);
        chk("drop_full", 64'(drop_full), m_dfull);
        chk("drop_busy", 64'(drop_busy), m_dbusy);
        if (done_pulse === 1'b1) n_done_seen++;
        busy = xb || (cyc_no >= busy_from && cyc_no < busy_to);
        cfg_mode        = c_mode[0];
        cfg_decim       = DECIM_W'(c_decim);
        cfg_burst_len   = CNT_W'(c_len);
        cmd_start       = st;
        cmd_stop        = sp;
        cmd_clr_cnt     = cl;
        adc_frame_valid = fv;
        fifo_level      = LEVEL_W'(lvl);
        seq_busy        = busy;
        #1;
        blocked = busy || m_pend;
        room    = (lvl <= FIFO_DEPTH) && ((FIFO_DEPTH - lvl) >= WORDS_OUT);
        sel     = m_run && fv && ((m_frame_no % (m_decim + 1)) == 0);
        fwd     = sel && !blocked && room;
        chk("seq_frame_valid", 64'(seq_frame_valid), 64'(fwd));
        @(posedge clk);
        m_done = 0;
        if (cl) begin
            m_acc = 0; m_dfull = 0; m_dbusy = 0;
        end else begin
            if (fwd && m_acc < 64'hFFFF_FFFF) m_acc++;
            if (sel && blocked && m_dbusy < 64'hFFFF) m_dbusy++;
            if (sel && !blocked && !room && m_dfull < 64'hFFFF) m_dfull++;
        end
        was_pend = m_pend;
        if (!m_run && !m_drain) begin
            if (st && !sp) begin
                m_burst = c_mode[0]; m_decim = c_decim; m_frame_no = 0; m_left = c_len;
                if (m_burst && m_left == 0) m_drain = 1; else m_run = 1;
            end
        end else if (m_run) begin
            if (fv) m_frame_no++;
            if (fwd && m_burst) m_left--;
            if (sp || (m_burst && m_left == 0)) begin m_run = 0; m_drain = 1; end
        end else if (!was_pend && !busy) begin
            m_drain = 0; m_done = 1;
        end
        if (fwd) begin
            m_pend = 1; m_saw = 0;
            busy_from = cyc_no + 1 + g_gap;
            busy_to   = busy_from + g_blen;
        end else if (m_pend) begin
            if (busy) m_saw = 1;
            else if (m_saw) begin m_pend = 0; m_saw = 0; end
        end
        cyc_no++;
    endtask

    task automatic tick(input bit fv, input int unsigned lvl);
        cyc(0, 0, 0, fv, lvl, 0);
    endtask

    task automatic stop_and_idle();
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60 && (m_run || m_drain); i++) tick(0, 0);
        tick(0, 0);
        #1 chk("idle_reached", 64'(running), 64'd0);
    endtask

    task automatic spaced_frames(input int n, input int unsigned lvl);
        for (int f = 0; f < n; f++) begin
            tick(1, lvl);
            repeat (19) tick(0, lvl);
        end
    endtask

    initial begin
        rst_n = 0; cfg_mode = 0; cfg_decim = 0; cfg_burst_len = 0;
        cmd_start = 0; cmd_stop = 0; cmd_clr_cnt = 0; adc_frame_valid = 0;
        fifo_level = 0; seq_busy = 0; sc_inc = 0; sc_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_done", 64'(done_pulse), 64'd0);
        chk("rst_sfv", 64'(seq_frame_valid), 64'd0);
        chk("rst_acc", 64'(frames_accepted), 64'd0);
        chk("rst_dfull", 64'(drop_full), 64'd0);
        chk("rst_dbusy", 64'(drop_busy), 64'd0);
        rst_n = 1;

        // Continuous, no decimation; config changed mid-run must be ignored.
        c_mode = 0; c_decim = 0;
        cyc(1, 0, 0, 0, 0, 0);
        c_mode = 1; c_decim = 5; c_len = 1;
        spaced_frames(3, 0);
        #1 chk("cont_acc", 64'(frames_accepted), 64'd3);
        chk("cont_drops", 64'(drop_full) + 64'(drop_busy), 64'd0);
        stop_and_idle();

        // Decimation by 3.
        cyc(0, 0, 1, 0, 0, 0);
        c_mode = 0; c_decim = 2;
        cyc(1, 0, 0, 0, 0, 0);
        spaced_frames(9, 0);
        #1 chk("decim_acc", 64'(frames_accepted), 64'd3);
        chk("decim_drops", 64'(drop_full) + 64'(drop_busy), 64'd0);
        stop_and_idle();

        // FIFO space boundary: 56 leaves 8 slots, 55 leaves 9.
        cyc(0, 0, 1, 0, 0, 0);
        c_decim = 0;
        cyc(1, 0, 0, 0, 0, 0);
        tick(1, 56);
        #1 chk("space56_dfull", 64'(drop_full), 64'd1);
        chk("space56_acc", 64'(frames_accepted), 64'd0);
        repeat (4) tick(0, 56);
        spaced_frames(1, 55);
        #1 chk("space55_acc", 64'(frames_accepted), 64'd1);
        chk("space55_dfull", 64'(drop_full), 64'd1);

        // Busy: frame in the gap before busy rises, then a frame while busy.
        cyc(0, 0, 1, 0, 0, 0);
        g_gap = 1; g_blen = 3;
        tick(1, 0);
        tick(1, 0);
        tick(1, 0);
        repeat (20) tick(0, 0);
        #1 chk("busy_dbusy", 64'(drop_busy), 64'd2);
        chk("busy_acc", 64'(frames_accepted), 64'd1);
        stop_and_idle();

        // Burst of 2 out of 4 frames, then a zero-length burst.
        cyc(0, 0, 1, 0, 0, 0);
        c_mode = 1; c_len = 2; c_decim = 0;
        n_done_seen = 0;
        cyc(1, 0, 0, 0, 0, 0);
        tick(1, 0);
        repeat (19) tick(0, 0);
        tick(1, 0);
        #1 chk("burst_draining", 64'(running), 64'd1);
        repeat (19) tick(0, 0);
        spaced_frames(2, 0);
        #1 chk("burst_acc", 64'(frames_accepted), 64'd2);
        chk("burst_done_cycles", 64'(n_done_seen), 64'd1);
        chk("burst_idle", 64'(running), 64'd0);
        c_len = 0; n_done_seen = 0;
        cyc(1, 0, 0, 0, 0, 0);
        repeat (4) tick(1, 0);
        #1 chk("len0_done_cycles", 64'(n_done_seen), 64'd1);
        chk("len0_acc", 64'(frames_accepted), 64'd2);

        // Start and stop together in IDLE do nothing.
        c_mode = 0;
        cyc(1, 1, 0, 0, 0, 0);
        tick(0, 0);
        #1 chk("start_stop_idle", 64'(running), 64'd0);

        // Clear wins over a same-cycle increment.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        #1 chk("clr_wins", 64'(frames_accepted), 64'd0);
        repeat (10) tick(0, 0);
        stop_and_idle();

        // Saturation near max on a narrow counter instance.
        @(negedge clk) sc_inc = 1;
        repeat (14) @(negedge clk);
        chk("sat4_near", 64'(sc_q), 64'd14);
        repeat (6) @(negedge clk);
        chk("sat4_hold", 64'(sc_q), 64'd15);
        sc_clr = 1;
        @(negedge clk);
        chk("sat4_clr", 64'(sc_q), 64'd0);
        sc_clr = 0; sc_inc = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            c_mode  = $urandom_range(1, 0);
            c_decim = $urandom_range(3, 0);
            c_len   = $urandom_range(4, 0);
            g_gap   = $urandom_range(1, 0);
            g_blen  = $urandom_range(5, 1);
            cyc($urandom_range(99, 0) < 6, $urandom_range(99, 0) < 3,
                $urandom_range(99, 0) < 2, $urandom_range(99, 0) < 40,
                $urandom_range(72, 40), $urandom_range(99, 0) < 4);
        end
        stop_and_idle();

        // Asynchronous reset in the middle of a run.
        g_gap = 1; g_blen = 3; c_mode = 0; c_decim = 0;
        cyc(1, 0, 0, 0, 0, 0);
        tick(1, 0);
        repeat (10) tick(0, 0);
        @(negedge clk);
        cmd_start = 0; cmd_stop = 0; cmd_clr_cnt = 0;
        adc_frame_valid = 1; fifo_level = 0; seq_busy = 0;
        #1 chk("pre_rst_sfv", 64'(seq_frame_valid), 64'd1);
        rst_n = 0;
        #1 chk("arst_running", 64'(running), 64'd0);
        chk("arst_sfv", 64'(seq_frame_valid), 64'd0);
        chk("arst_acc", 64'(frames_accepted), 64'd0);
        @(negedge clk);
        adc_frame_valid = 0;
        rst_n = 1;
        model_reset();
        repeat (3) tick(1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
